// File: rtl/cv32e40p_trace_buffer.sv
// Event trace buffer: samples up to NUM_SRC event sources per cycle, stamps the
// lowest-index valid event with a free-running cycle timestamp and stores it in
// a circular buffer drained through a valid/ready read port. When full, new
// events are either dropped (WRAP_MODE=0) or overwrite the oldest entry
// (WRAP_MODE=1); every lost event is counted in a saturating drop counter.
module cv32e40p_trace_buffer #(
   parameter int NUM_SRC    = 2,
   parameter int DEPTH      = 16,
   parameter int DATA_W     = 32,
   parameter bit WRAP_MODE  = 1'b0,
   parameter int DROP_CNT_W = 16,
   localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
   localparam int CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             enable_i,
   input  logic                             clear_i,
   input  logic [NUM_SRC-1:0]               ev_valid_i,
   input  logic [NUM_SRC-1:0][31:0]         ev_pc_i,
   input  logic [NUM_SRC-1:0][DATA_W-1:0]   ev_data_i,
   output logic                             rd_valid_o,
   input  logic                             rd_ready_i,
   output logic [SRC_W-1:0]                 rd_src_o,
   output logic [31:0]                      rd_ts_o,
   output logic [31:0]                      rd_pc_o,
   output logic [DATA_W-1:0]                rd_data_o,
   output logic [CNT_W-1:0]                 count_o,
   output logic                             full_o,
   output logic                             overflow_o,
   output logic [DROP_CNT_W-1:0]            drop_cnt_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = SRC_W + 32 + 32 + DATA_W;
   // Wide enough to hold NUM_SRC (all losers plus one lost winner).
   localparam int ADD_W = $clog2(NUM_SRC + 1);
   localparam int SUM_W = ((DROP_CNT_W > ADD_W) ? DROP_CNT_W : ADD_W) + 1;
   localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

   // Timestamp and buffer state
   logic [31:0]            ts_reg;
   logic [PTR_W-1:0]       wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]       rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]       count_reg, count_next;
   logic [DROP_CNT_W-1:0]  drop_cnt_reg, drop_cnt_next;
   logic                   overflow_reg, overflow_next;

   // Entry storage: {src, ts, pc, data}
   logic [ENT_W-1:0]       mem [DEPTH];
   logic [ENT_W-1:0]       rd_entry_reg;
   logic [ENT_W-1:0]       wr_entry;

   // Arbitration results
   logic [NUM_SRC-1:0]     ev_take;
   logic                   found;
   logic [SRC_W-1:0]       win_src;
   logic [31:0]            win_pc;
   logic [DATA_W-1:0]      win_data;
   logic [ADD_W-1:0]       ev_cnt;
   logic [ADD_W-1:0]       losers;
   logic [ADD_W-1:0]       drop_add;
   logic [SUM_W-1:0]       drop_sum;

   // Control strobes
   logic                   kill;
   logic                   rd_valid;
   logic                   full;
   logic                   pop;
   logic                   push;
   logic                   overwrite;
   logic                   lost_winner;
   logic                   wr_en;

   // Events only count while capture is enabled.
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_take
      assign ev_take[gi] = enable_i & ev_valid_i[gi];
   end

   // Pick the lowest-index valid source and count how many sources fired.
   always_comb begin
      found    = 1'b0;
      win_src  = '0;
      win_pc   = '0;
      win_data = '0;
      ev_cnt   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (ev_take[i]) begin
            ev_cnt = ev_cnt + ADD_W'(1);
            if (!found) begin
               found    = 1'b1;
               win_src  = SRC_W'(i);
               win_pc   = ev_pc_i[i];
               win_data = ev_data_i[i];
            end
         end
      end
      losers = found ? (ev_cnt - ADD_W'(1)) : '0;
   end

   assign kill        = ~rst_ni | clear_i;
   assign rd_valid    = (count_reg != '0);
   assign full        = (count_reg == CNT_W'(DEPTH));
   assign pop         = rd_valid & rd_ready_i;
   // A pop in the same cycle frees a slot, so full only blocks when no pop.
   assign push        = found & (~full | pop | WRAP_MODE);
   assign overwrite   = found & full & ~pop & WRAP_MODE;
   assign lost_winner = found & full & ~pop;
   assign wr_en       = push & ~kill;
   assign drop_add    = losers + ADD_W'(lost_winner);
   assign drop_sum    = SUM_W'(drop_cnt_reg) + SUM_W'(drop_add);
   assign wr_entry    = {win_src, ts_reg, win_pc, win_data};

   // Next-state for pointers, occupancy and loss accounting; clear/reset win.
   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;
      drop_cnt_next = drop_cnt_reg;
      overflow_next = overflow_reg;
      if (kill) begin
         wr_ptr_next   = '0;
         rd_ptr_next   = '0;
         count_next    = '0;
         drop_cnt_next = '0;
         overflow_next = 1'b0;
      end else begin
         wr_ptr_next = wr_ptr_reg + PTR_W'(push);
         // An overwrite discards the oldest entry, so the head moves too.
         rd_ptr_next = rd_ptr_reg + PTR_W'(pop | overwrite);
         case ({push & ~overwrite, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
         endcase
         drop_cnt_next = (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX
                                                       : drop_sum[DROP_CNT_W-1:0];
         overflow_next = overflow_reg | (drop_add != '0);
      end
   end

   // Free-running timestamp, gated by enable and zeroed only by reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ts_reg <= '0;
      end else if (enable_i) begin
         ts_reg <= ts_reg + 32'd1;
      end
   end

   // Buffer control state register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         drop_cnt_reg <= '0;
         overflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         drop_cnt_reg <= drop_cnt_next;
         overflow_reg <= overflow_next;
      end
   end

   // Storage write port; contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_ptr_reg] <= wr_entry;
      end
   end

   // Registered head read addressed by the next read pointer, so the new head
   // is on rd_* in the cycle the pointer updates. When the entry being written
   // is the next head (push into an empty buffer, or push+pop of the last
   // entry) the write data is forwarded because the array still holds stale data.
   always_ff @(posedge clk_i) begin
      if (wr_en && (wr_ptr_reg == rd_ptr_next)) begin
         rd_entry_reg <= wr_entry;
      end else begin
         rd_entry_reg <= mem[rd_ptr_next];
      end
   end

   assign rd_valid_o = rd_valid;
   assign {rd_src_o, rd_ts_o, rd_pc_o, rd_data_o} = rd_valid ? rd_entry_reg : '0;
   assign count_o    = count_reg;
   assign full_o     = full;
   assign overflow_o = overflow_reg;
   assign drop_cnt_o = drop_cnt_reg;

endmodule

// File: tb/tb_cv32e40p_trace_buffer.sv
// Bench for the trace buffer: two instances (DEPTH=4, stop-on-full with a
// 2-bit drop counter, and overwrite-oldest with a 16-bit drop counter) share
// one directed stimulus stream. A queue-based scoreboard per instance holds the
// expected buffer contents and is compared after every clock, alongside
// directed constant checks at the key points.
module tb_cv32e40p_trace_buffer;

   typedef struct packed {
      logic [0:0]  src;
      logic [31:0] ts;
      logic [31:0] pc;
      logic [31:0] data;
   } ent_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             enable;
   logic             clear;
   logic             rd_ready;
   logic [1:0]       ev_valid;
   logic [1:0][31:0] ev_pc;
   logic [1:0][31:0] ev_data;

   logic        rd_valid_a, rd_valid_b;
   logic [0:0]  rd_src_a, rd_src_b;
   logic [31:0] rd_ts_a, rd_ts_b;
   logic [31:0] rd_pc_a, rd_pc_b;
   logic [31:0] rd_data_a, rd_data_b;
   logic [2:0]  count_a, count_b;
   logic        full_a, full_b;
   logic        overflow_a, overflow_b;
   logic [1:0]  drop_a;
   logic [15:0] drop_b;

   int checks = 0;
   int errors = 0;

   ent_t            mq [2][$];
   longint unsigned mdrop [2];
   bit              movf [2];
   logic [31:0]     mts = '0;

   always #5 clk = ~clk;

   cv32e40p_trace_buffer #(
      .NUM_SRC(2), .DEPTH(4), .DATA_W(32), .WRAP_MODE(1'b0), .DROP_CNT_W(2)
   ) u_stop (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
      .ev_valid_i(ev_valid), .ev_pc_i(ev_pc), .ev_data_i(ev_data),
      .rd_valid_o(rd_valid_a), .rd_ready_i(rd_ready), .rd_src_o(rd_src_a),
      .rd_ts_o(rd_ts_a), .rd_pc_o(rd_pc_a), .rd_data_o(rd_data_a),
      .count_o(count_a), .full_o(full_a), .overflow_o(overflow_a),
      .drop_cnt_o(drop_a)
   );

   cv32e40p_trace_buffer #(
      .NUM_SRC(2), .DEPTH(4), .DATA_W(32), .WRAP_MODE(1'b1), .DROP_CNT_W(16)
   ) u_wrap (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
      .ev_valid_i(ev_valid), .ev_pc_i(ev_pc), .ev_data_i(ev_data),
      .rd_valid_o(rd_valid_b), .rd_ready_i(rd_ready), .rd_src_o(rd_src_b),
      .rd_ts_o(rd_ts_b), .rd_pc_o(rd_pc_b), .rd_data_o(rd_data_b),
      .count_o(count_b), .full_o(full_b), .overflow_o(overflow_b),
      .drop_cnt_o(drop_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard update for one clock edge, using the inputs about to be sampled.
   task automatic model_step(input logic r, input logic en, input logic cl,
                             input logic [1:0] v, input logic rdy);
      int              sz;
      bit              popped;
      longint unsigned add;
      longint unsigned dmax;
      ent_t            w;
      w.src  = v[0] ? 1'b0 : 1'b1;
      w.ts   = mts;
      w.pc   = v[0] ? ev_pc[0] : ev_pc[1];
      w.data = v[0] ? ev_data[0] : ev_data[1];
      for (int k = 0; k < 2; k++) begin
         if (r || cl) begin
            mq[k].delete();
            mdrop[k] = 0;
            movf[k]  = 1'b0;
         end else begin
            sz     = mq[k].size();
            popped = rdy && (sz > 0);
            add    = 0;
            if (popped) void'(mq[k].pop_front());
            if (en && (v != 2'b00)) begin
               add = (v == 2'b11) ? 1 : 0;
               if (sz < 4 || popped) begin
                  mq[k].push_back(w);
               end else if (k == 0) begin
                  add = add + 1;
               end else begin
                  void'(mq[k].pop_front());
                  mq[k].push_back(w);
                  add = add + 1;
               end
            end
            dmax     = (k == 0) ? 3 : 65535;
            mdrop[k] = mdrop[k] + add;
            if (mdrop[k] > dmax) mdrop[k] = dmax;
            if (add > 0) movf[k] = 1'b1;
         end
      end
      if (r) mts = '0;
      else if (en) mts = mts + 32'd1;
   endtask

   task automatic check_inst(input int k, input string n, input logic v,
                             input logic [2:0] cnt, input logic f, input logic o,
                             input logic [15:0] d, input ent_t h);
      ent_t e;
      e = '0;
      if (mq[k].size() > 0) e = mq[k][0];
      chk({n, "_valid"},    64'(v),      64'(mq[k].size() > 0));
      chk({n, "_count"},    64'(cnt),    64'(mq[k].size()));
      chk({n, "_full"},     64'(f),      64'(mq[k].size() == 4));
      chk({n, "_overflow"}, 64'(o),      64'(movf[k]));
      chk({n, "_drop"},     64'(d),      64'(mdrop[k]));
      chk({n, "_src"},      64'(h.src),  64'(e.src));
      chk({n, "_ts"},       64'(h.ts),   64'(e.ts));
      chk({n, "_pc"},       64'(h.pc),   64'(e.pc));
      chk({n, "_data"},     64'(h.data), 64'(e.data));
   endtask

   // Drive one cycle of stimulus, advance the scoreboard, then compare.
   task automatic tick(input logic r, input logic en, input logic cl,
                       input logic [1:0] v, input logic rdy,
                       input logic [31:0] p0, input logic [31:0] p1);
      rst_n      = ~r;
      enable     = en;
      clear      = cl;
      ev_valid   = v;
      rd_ready   = rdy;
      ev_pc[0]   = p0;
      ev_pc[1]   = p1;
      ev_data[0] = p0 ^ 32'hDEAD_0000;
      ev_data[1] = p1 ^ 32'hBEEF_0000;
      model_step(r, en, cl, v, rdy);
      @(posedge clk);
      #1;
      check_inst(0, "stop", rd_valid_a, count_a, full_a, overflow_a, {14'd0, drop_a},
                 {rd_src_a, rd_ts_a, rd_pc_a, rd_data_a});
      check_inst(1, "wrap", rd_valid_b, count_b, full_b, overflow_b, drop_b,
                 {rd_src_b, rd_ts_b, rd_pc_b, rd_data_b});
   endtask

   task automatic push(input logic [31:0] p);
      tick(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, p, 32'h0);
   endtask

   task automatic pop();
      tick(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0);
   endtask

   task automatic do_clear();
      tick(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      rst_n    = 1'b0;
      enable   = 1'b0;
      clear    = 1'b0;
      rd_ready = 1'b0;
      ev_valid = '0;
      ev_pc    = '0;
      ev_data  = '0;

      // Reset
      tick(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      tick(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      chk("rst_count", 64'(count_a), 64'd0);
      chk("rst_valid", 64'(rd_valid_a), 64'd0);
      chk("rst_full", 64'(full_a), 64'd0);
      chk("rst_drop", 64'(drop_b), 64'd0);
      chk("rst_pc_zero", 64'(rd_pc_a), 64'd0);

      // Single source, three consecutive events
      push(32'h1000);
      chk("t1_valid_rise", 64'(rd_valid_a), 64'd1);
      push(32'h1004);
      push(32'h1008);
      chk("t1_count", 64'(count_a), 64'd3);
      for (int i = 0; i < 3; i++) begin
         chk("t1_ts", 64'(rd_ts_a), 64'(i));
         chk("t1_pc", 64'(rd_pc_a), 64'(32'h1000 + 4 * i));
         pop();
      end

      // Simultaneous events: source 0 wins, source 1 is lost
      tick(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h200);
      chk("t2_src", 64'(rd_src_a), 64'd0);
      chk("t2_pc", 64'(rd_pc_a), 64'h100);
      chk("t2_drop", 64'(drop_a), 64'd1);
      chk("t2_ovf", 64'(overflow_a), 64'd1);
      pop();
      do_clear();
      chk("clr_drop", 64'(drop_a), 64'd0);
      chk("clr_ovf", 64'(overflow_b), 64'd0);

      // Six events into a depth-4 buffer without pops
      for (int k = 1; k <= 6; k++) push(32'(32'h10 * k));
      chk("t3_count_stop", 64'(count_a), 64'd4);
      chk("t3_full_stop", 64'(full_a), 64'd1);
      chk("t3_drop_stop", 64'(drop_a), 64'd2);
      chk("t3_count_wrap", 64'(count_b), 64'd4);
      chk("t3_drop_wrap", 64'(drop_b), 64'd2);
      for (int i = 0; i < 4; i++) begin
         chk("t3_pc_stop", 64'(rd_pc_a), 64'(32'h10 * (i + 1)));
         chk("t3_pc_wrap", 64'(rd_pc_b), 64'(32'h10 * (i + 3)));
         pop();
      end

      // Full with push and pop in the same cycle
      do_clear();
      for (int k = 1; k <= 4; k++) push(32'(32'h20 * k));
      tick(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h500, 32'h0);
      chk("t4_count_stop", 64'(count_a), 64'd4);
      chk("t4_count_wrap", 64'(count_b), 64'd4);
      chk("t4_drop_stop", 64'(drop_a), 64'd0);
      chk("t4_drop_wrap", 64'(drop_b), 64'd0);
      chk("t4_head_stop", 64'(rd_pc_a), 64'h40);
      chk("t4_head_wrap", 64'(rd_pc_b), 64'h40);
      for (int i = 0; i < 4; i++) pop();

      // Drop counter saturation
      do_clear();
      for (int k = 0; k < 5; k++)
         tick(1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 32'(32'h300 + k), 32'(32'h400 + k));
      chk("t5_sat_stop", 64'(drop_a), 64'd3);
      chk("t5_drop_wrap", 64'(drop_b), 64'd5);
      pop();

      // Clear together with a push
      tick(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'h700, 32'h0);
      chk("t6_count", 64'(count_a), 64'd0);
      chk("t6_drop", 64'(drop_b), 64'd0);
      chk("t6_ovf", 64'(overflow_a), 64'd0);
      push(32'h800);
      pop();

      // Capture disabled: events ignored, timestamp holds
      tick(1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'h900, 32'h904);
      chk("t7_count", 64'(count_a), 64'd0);
      tick(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h908, 32'h90C);
      tick(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h910);
      chk("t7_src", 64'(rd_src_b), 64'd1);
      pop();

      // Reset in the middle of operation
      push(32'hA00);
      push(32'hA04);
      tick(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'hA08, 32'h0);
      chk("t8_count", 64'(count_a), 64'd0);
      chk("t8_valid", 64'(rd_valid_b), 64'd0);
      push(32'hB00);
      chk("t8_ts_restart", 64'(rd_ts_a), 64'd0);
      pop();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
